// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC select codes,
// increment size and default reset/trap vectors.
package pc_pkg;

  localparam logic [2:0] SEL_SEQ    = 3'd0;
  localparam logic [2:0] SEL_BRANCH = 3'd1;
  localparam logic [2:0] SEL_JUMP   = 3'd2;
  localparam logic [2:0] SEL_JREG   = 3'd3;
  localparam logic [2:0] SEL_TRAP   = 3'd4;
  localparam logic [2:0] SEL_ERET   = 3'd5;

  localparam int PC_INC = 4;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h0000_0180;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection, including trap and exception-return decode.
// A misaligned register jump is redirected to the trap vector.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(DEFAULT_TRAP_VEC)
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_epc,
  input  logic [2:0]      i_next_sel,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_imm_offset,
  input  logic [25:0]     i_jump_index,
  input  logic [XLEN-1:0] i_reg_target,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_take_trap,
  output logic            o_misalign,
  output logic            o_eret
);

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_branch_tgt;
  logic [XLEN-1:0] w_jump_tgt;

  assign w_pc_plus4   = i_pc + XLEN'(PC_INC);
  assign w_branch_tgt = w_pc_plus4 + (i_imm_offset << 2);
  assign w_jump_tgt   = {w_pc_plus4[XLEN-1:28], i_jump_index, 2'b00};
  assign o_pc_plus4   = w_pc_plus4;

  // Reserved select codes fall through to the sequential default.
  always_comb begin
    o_next_pc   = w_pc_plus4;
    o_take_trap = 1'b0;
    o_misalign  = 1'b0;
    o_eret      = 1'b0;
    case (i_next_sel)
      SEL_BRANCH: if (i_branch_taken) o_next_pc = w_branch_tgt;
      SEL_JUMP:   o_next_pc = w_jump_tgt;
      SEL_JREG: begin
        if (i_reg_target[1:0] == 2'b00) begin
          o_next_pc = i_reg_target;
        end else begin
          o_next_pc   = TRAP_VEC;
          o_take_trap = 1'b1;
          o_misalign  = 1'b1;
        end
      end
      SEL_TRAP: begin
        o_next_pc   = TRAP_VEC;
        o_take_trap = 1'b1;
      end
      SEL_ERET: begin
        o_next_pc = i_epc;
        o_eret    = 1'b1;
      end
      default: o_next_pc = w_pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC, EPC, trap/misalign flags and retired-write counter.
// Next-PC selection lives in pc_next_calc; this module only holds the state.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEFAULT_TRAP_VEC),
  parameter int              CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_pc_we,
  input  logic [2:0]       i_next_sel,
  input  logic             i_branch_taken,
  input  logic [XLEN-1:0]  i_imm_offset,
  input  logic [25:0]      i_jump_index,
  input  logic [XLEN-1:0]  i_reg_target,
  output logic [XLEN-1:0]  o_pc_out,
  output logic [XLEN-1:0]  o_pc_plus4,
  output logic [XLEN-1:0]  o_epc_out,
  output logic             o_in_trap,
  output logic             o_misalign_err,
  output logic [CNT_W-1:0] o_retire_count
);

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_epc;
  logic             r_in_trap;
  logic             r_misalign;
  logic [CNT_W-1:0] r_retire_count;

  logic [XLEN-1:0]  w_next_pc;
  logic             w_take_trap;
  logic             w_misalign;
  logic             w_eret;

  pc_next_calc #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC)
  ) u_next (
    .i_pc           (r_pc),
    .i_epc          (r_epc),
    .i_next_sel     (i_next_sel),
    .i_branch_taken (i_branch_taken),
    .i_imm_offset   (i_imm_offset),
    .i_jump_index   (i_jump_index),
    .i_reg_target   (i_reg_target),
    .o_pc_plus4     (o_pc_plus4),
    .o_next_pc      (w_next_pc),
    .o_take_trap    (w_take_trap),
    .o_misalign     (w_misalign),
    .o_eret         (w_eret)
  );

  // A nested trap simply overwrites EPC; there is no EPC stack.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc           <= RESET_VEC;
      r_epc          <= '0;
      r_in_trap      <= 1'b0;
      r_misalign     <= 1'b0;
      r_retire_count <= '0;
    end else if (i_pc_we) begin
      r_pc           <= w_next_pc;
      r_retire_count <= r_retire_count + CNT_W'(1);
      if (w_take_trap) begin
        r_epc     <= r_pc;
        r_in_trap <= 1'b1;
        if (w_misalign) r_misalign <= 1'b1;
      end else if (w_eret) begin
        r_in_trap  <= 1'b0;
        r_misalign <= 1'b0;
      end
    end
  end

  assign o_pc_out       = r_pc;
  assign o_epc_out      = r_epc;
  assign o_in_trap      = r_in_trap;
  assign o_misalign_err = r_misalign;
  assign o_retire_count = r_retire_count;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an arithmetic reference model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pcWe = 1'b0;
  logic [2:0]  nextSel = 3'd0;
  logic        branchTaken = 1'b0;
  logic [31:0] immOffset = '0;
  logic [25:0] jumpIndex = '0;
  logic [31:0] regTarget = '0;
  logic [31:0] pcOut, pcPlus4, epcOut, retireCount;
  logic        inTrap, misalignErr;

  logic [31:0] mPc = '0, mEpc = '0, mCnt = '0;
  logic        mTrap = 1'b0, mMis = 1'b0;
  logic        cmpEn = 1'b0;
  int          checks = 0;
  int          errors = 0;

  localparam logic [31:0] TRAPV = 32'h0000_0180;

  pc_unit dut (
    .clk            (clk),
    .reset          (reset),
    .i_pc_we        (pcWe),
    .i_next_sel     (nextSel),
    .i_branch_taken (branchTaken),
    .i_imm_offset   (immOffset),
    .i_jump_index   (jumpIndex),
    .i_reg_target   (regTarget),
    .o_pc_out       (pcOut),
    .o_pc_plus4     (pcPlus4),
    .o_epc_out      (epcOut),
    .o_in_trap      (inTrap),
    .o_misalign_err (misalignErr),
    .o_retire_count (retireCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, outputs must match the model state after the latest posedge.
  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("pc_out", pcOut, mPc);
      checkOutput("pc_plus4", pcPlus4, mPc + 32'd4);
      checkOutput("epc_out", epcOut, mEpc);
      checkOutput("in_trap", {31'd0, inTrap}, {31'd0, mTrap});
      checkOutput("misalign_err", {31'd0, misalignErr}, {31'd0, mMis});
      checkOutput("retire_count", retireCount, mCnt);
    end
  end

  // Drive one cycle of inputs and advance the model by the architectural rules.
  task automatic applyStimulus(input logic rst, input logic we, input logic [2:0] sel,
                               input logic taken, input logic [31:0] imm,
                               input logic [25:0] jidx, input logic [31:0] tgt);
    logic [31:0] nPc, nEpc, nCnt;
    logic        nTrap, nMis;
    reset = rst; pcWe = we; nextSel = sel;
    branchTaken = taken; immOffset = imm; jumpIndex = jidx; regTarget = tgt;
    nPc = mPc; nEpc = mEpc; nCnt = mCnt; nTrap = mTrap; nMis = mMis;
    if (rst) begin
      nPc = 32'h0; nEpc = 32'h0; nCnt = 32'h0; nTrap = 1'b0; nMis = 1'b0;
    end else if (we) begin
      nCnt = mCnt + 32'd1;
      case (sel)
        3'd1: nPc = taken ? mPc + 32'd4 + imm * 32'd4 : mPc + 32'd4;
        3'd2: nPc = ((mPc + 32'd4) & 32'hF000_0000) | (32'(jidx) * 32'd4);
        3'd3: begin
          if (tgt % 32'd4 == 32'd0) nPc = tgt;
          else begin nPc = TRAPV; nEpc = mPc; nTrap = 1'b1; nMis = 1'b1; end
        end
        3'd4: begin nPc = TRAPV; nEpc = mPc; nTrap = 1'b1; end
        3'd5: begin nPc = mEpc; nTrap = 1'b0; nMis = 1'b0; end
        default: nPc = mPc + 32'd4;
      endcase
    end
    @(posedge clk);
    #1;
    mPc = nPc; mEpc = nEpc; mCnt = nCnt; mTrap = nTrap; mMis = nMis;
  endtask

  task automatic go(input logic [2:0] sel, input logic taken, input logic [31:0] imm,
                    input logic [25:0] jidx, input logic [31:0] tgt);
    applyStimulus(1'b0, 1'b1, sel, taken, imm, jidx, tgt);
  endtask

  task automatic jr(input logic [31:0] tgt);
    go(3'd3, 1'b0, 32'h0, 26'h0, tgt);
  endtask

  initial begin
    logic [31:0] r, imm, tgt;
    logic [2:0]  sel;

    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0);
    cmpEn = 1'b1;
    checkOutput("rst_pc", pcOut, 32'h0);
    checkOutput("rst_epc", epcOut, 32'h0);
    checkOutput("rst_cnt", retireCount, 32'h0);

    for (int i = 0; i < 3; i++) go(3'd0, 1'b0, 32'h0, 26'h0, 32'h0);
    checkOutput("seq_pc", pcOut, 32'hC);
    checkOutput("seq_cnt", retireCount, 32'd3);
    checkOutput("seq_plus4", pcPlus4, 32'h10);

    jr(32'h100);
    go(3'd1, 1'b1, 32'hFFFF_FFFE, 26'h0, 32'h0);
    checkOutput("br_taken", pcOut, 32'hFC);
    jr(32'h100);
    go(3'd1, 1'b0, 32'hFFFF_FFFE, 26'h0, 32'h0);
    checkOutput("br_not_taken", pcOut, 32'h104);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 3'd4, 1'b0, 32'h0, 26'h0, 32'h0);
    checkOutput("hold_pc", pcOut, 32'h104);
    checkOutput("hold_cnt", retireCount, 32'd7);

    jr(32'h1000_0040);
    go(3'd2, 1'b0, 32'h0, 26'h10, 32'h0);
    checkOutput("jump_pc", pcOut, 32'h1000_0040);
    jr(32'h200);
    checkOutput("jreg_pc", pcOut, 32'h200);

    jr(32'h300);
    jr(32'h202);
    checkOutput("mis_pc", pcOut, 32'h180);
    checkOutput("mis_epc", epcOut, 32'h300);
    checkOutput("mis_trap", {31'd0, inTrap}, 32'd1);
    checkOutput("mis_flag", {31'd0, misalignErr}, 32'd1);
    go(3'd5, 1'b0, 32'h0, 26'h0, 32'h0);
    checkOutput("eret_pc", pcOut, 32'h300);
    checkOutput("eret_flag", {31'd0, misalignErr}, 32'd0);

    jr(32'h400);
    go(3'd4, 1'b0, 32'h0, 26'h0, 32'h0);
    checkOutput("trap_epc", epcOut, 32'h400);
    go(3'd4, 1'b0, 32'h0, 26'h0, 32'h0);
    checkOutput("nest_epc", epcOut, 32'h180);
    checkOutput("nest_trap", {31'd0, inTrap}, 32'd1);
    go(3'd5, 1'b0, 32'h0, 26'h0, 32'h0);
    checkOutput("nest_eret_pc", pcOut, 32'h180);

    jr(32'hFFFF_FFFC);
    go(3'd0, 1'b0, 32'h0, 26'h0, 32'h0);
    checkOutput("wrap_pc", pcOut, 32'h0);
    go(3'd4, 1'b0, 32'h0, 26'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 3'd4, 1'b0, 32'h0, 26'h0, 32'h0);
    checkOutput("rst2_pc", pcOut, 32'h0);
    checkOutput("rst2_epc", epcOut, 32'h0);
    checkOutput("rst2_trap", {31'd0, inTrap}, 32'd0);
    checkOutput("rst2_cnt", retireCount, 32'd0);

    for (int i = 0; i < 600; i++) begin
      sel = 3'($urandom_range(0, 7));
      imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 63)) - 32'd32;
      r = $urandom;
      tgt = ($urandom_range(0, 3) != 0) ? (r & 32'hFFFF_FFFC) : r;
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0, sel,
                    1'($urandom_range(0, 1)), imm, 26'($urandom), tgt);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the multi-cycle CPU. It combines the PC register, next-PC selection (sequential, branch, jump, jump-register, trap, exception return), an exception PC (EPC) capture register and a retired-write counter. It sits at the front of the fetch stage. It drives instruction-memory address and PC+4 to the datapath, and takes control from the control unit.

Parameters:
XLEN, 32, PC/data width; must be >= 32
RESET_VEC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0180, PC value loaded on trap or misaligned jump
CNT_W, 32, width of retire_count

Ports:
clk  in  1  clock, rising-edge
reset  in  1  synchronous, active-high
pc_we  in  1  PC write enable; 0 holds all state
next_sel  in  3  0 SEQ, 1 BRANCH, 2 JUMP, 3 JREG, 4 TRAP, 5 ERET, 6/7 reserved
branch_taken  in  1  qualifies BRANCH
imm_offset  in  XLEN  sign-extended word offset, for BRANCH
jump_index  in  26  instr_index field, for JUMP
reg_target  in  XLEN  register target, for JREG
pc_out  out  XLEN  current PC, registered
pc_plus4  out  XLEN  pc_out + 4, combinational
epc_out  out  XLEN  exception PC, registered
in_trap  out  1  high between trap entry and ERET
misalign_err  out  1  sticky flag: JREG target not word-aligned
retire_count  out  CNT_W  number of accepted PC writes

Behaviour:
- Reset is synchronous, active-high, on clk; it is the only reset. While reset=1 at a posedge: pc_out=RESET_VEC, epc_out=0, in_trap=0, misalign_err=0, retire_count=0. Reset overrides pc_we and next_sel.
- pc_we=0: pc_out, epc_out, in_trap, misalign_err and retire_count all hold. pc_plus4 still tracks pc_out.
- pc_we=1: one-cycle latency; the new pc_out is visible after the posedge. retire_count increments by 1 and wraps modulo 2^CNT_W.
- All address arithmetic is modulo 2^XLEN. pc_out=32'hFFFF_FFFC with SEQ gives 0. Branch overflow wraps silently.
- Next-PC by next_sel:
  - SEQ: pc+4.
  - BRANCH: branch_taken ? pc+4+(imm_offset<<2) : pc+4.
  - JUMP: {pc_plus4[XLEN-1:28], jump_index, 2'b00}.
  - JREG, reg_target[1:0]==0: reg_target.
  - JREG, reg_target[1:0]!=0: treated as a trap. pc=TRAP_VEC, epc=pc_out, in_trap=1, misalign_err=1.
  - TRAP: pc=TRAP_VEC, epc=pc_out (address of the trapping instruction), in_trap=1.
  - ERET: pc=epc_out, in_trap=0, misalign_err=0. ERET with in_trap=0 still loads epc_out.
  - Reserved 6/7: behave as SEQ.
- Nested trap (TRAP while in_trap=1): epc is overwritten with the current pc_out and in_trap stays 1. No EPC stack.
- epc_out changes only on a trap entry or on reset.
- branch_taken, imm_offset, jump_index and reg_target are don't-care unless their next_sel is selected.
- No combinational path from pc_we or next_sel to pc_out.

Decomposition:
- Shared package pc_pkg holds:
  - next_sel encodings as localparams: SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_JREG, SEL_TRAP, SEL_ERET.
  - PC_INC=4.
  - Default RESET_VEC and TRAP_VEC.
- One natural sub-module: pc_next_calc. It is purely combinational: computes the next PC, the trap-take and misalign indications from pc_out, next_sel and the operand inputs.
- pc_unit keeps the registers: pc, epc, in_trap, misalign_err, retire_count.

Test Plan:
1. Reset, then 3 cycles of pc_we=1 with SEQ -> pc_out 0x0, 0x4, 0x8, 0xC; retire_count=3; pc_plus4=0x10.
2. pc_out=0x100, BRANCH, taken=1, imm_offset=-2 -> pc_out=0xFC. Repeat with taken=0 -> 0x104. Then pc_we=0 for 2 cycles -> pc_out holds and retire_count holds.
3. pc_out=0x1000_0040, JUMP, jump_index=0x000_0010 -> pc_out=0x1000_0040. Then JREG with reg_target=0x200 -> pc_out=0x200.
4. pc_out=0x300, JREG with reg_target=0x202 -> pc_out=0x180, epc_out=0x300, in_trap=1, misalign_err=1. Then ERET -> pc_out=0x300, in_trap=0, misalign_err=0.
5. pc_out=0x400, TRAP -> epc_out=0x400. At 0x180 issue TRAP again (nested) -> epc_out=0x180, in_trap=1. Then ERET -> pc_out=0x180.
6. pc_out=0xFFFF_FFFC, SEQ -> pc_out=0x0. Then assert reset together with pc_we=1, TRAP -> pc_out=RESET_VEC, epc_out=0, in_trap=0, retire_count=0.
